// File: rtl/wb_pkg.sv
// Shared types and sizes for the writeback stage: register-file geometry,
// result-source encoding and the holding-buffer entry layout.
package wb_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREG       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LSU,
        SRC_MDU
    } wb_src_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry valid/ready holding register for a long-latency result source.
// ready depends only on registered state; a drained entry refills next cycle.
module wb_hold_buf
    import wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]       in_data,
    input  logic                  direct,
    input  logic                  pop,
    output logic                  ready,
    output wb_entry_t             entry
);

    logic push;

    assign ready = !entry.valid;
    // A handshake forwarded straight to the write port never occupies the entry.
    assign push  = in_valid && ready && !direct;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= '0;
        end else if (push) begin
            entry.valid <= 1'b1;
            entry.rd    <= in_rd;
            entry.data  <= in_data;
        end else if (pop) begin
            entry.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_writer.sv
// Writeback merge of ALU, LSU and MDU results onto the single register-file
// write port, plus the pending-write scoreboard. Optional macro: WB_BYPASS_EN.
module wb_writer #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid,
    input  logic [wb_pkg::REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]               alu_data,
    input  logic                          lsu_valid,
    output logic                          lsu_ready,
    input  logic [wb_pkg::REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]               lsu_data,
    input  logic                          mdu_valid,
    output logic                          mdu_ready,
    input  logic [wb_pkg::REG_ADDR_W-1:0] mdu_rd,
    input  logic [XLEN-1:0]               mdu_data,
    input  logic                          issue_valid,
    input  logic [wb_pkg::REG_ADDR_W-1:0] issue_rd,
    output logic [NREG-1:0]               busy,
    output logic [wb_pkg::REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]               rf_result,
    output logic                          rf_reg_write
);

    import wb_pkg::*;

    wb_entry_t             lsu_buf;
    wb_entry_t             mdu_buf;
    logic                  lsu_direct;
    logic                  mdu_direct;
    logic                  lsu_pop;
    logic                  mdu_pop;
    logic                  rr_ptr;
    logic                  rr_ptr_next;
    wb_src_e               grant_src;
    logic [REG_ADDR_W-1:0] grant_rd;
    logic [XLEN-1:0]       grant_data;
    logic [NREG-1:0]       busy_next;

    wb_hold_buf u_lsu_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (lsu_valid),
        .in_rd    (lsu_rd),
        .in_data  (lsu_data),
        .direct   (lsu_direct),
        .pop      (lsu_pop),
        .ready    (lsu_ready),
        .entry    (lsu_buf)
    );

    wb_hold_buf u_mdu_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (mdu_valid),
        .in_rd    (mdu_rd),
        .in_data  (mdu_data),
        .direct   (mdu_direct),
        .pop      (mdu_pop),
        .ready    (mdu_ready),
        .entry    (mdu_buf)
    );

    // rr_ptr names the preferred source; after a contested grant it flips to the loser.
    always_comb begin
        grant_src   = SRC_NONE;
        lsu_direct  = 1'b0;
        mdu_direct  = 1'b0;
        rr_ptr_next = rr_ptr;
        if (alu_valid) begin
            grant_src = SRC_ALU;
        end else if (lsu_buf.valid && mdu_buf.valid) begin
            grant_src   = rr_ptr ? SRC_MDU : SRC_LSU;
            rr_ptr_next = !rr_ptr;
        end else if (lsu_buf.valid) begin
            grant_src = SRC_LSU;
        end else if (mdu_buf.valid) begin
            grant_src = SRC_MDU;
        end
`ifdef WB_BYPASS_EN
        else if (lsu_valid && mdu_valid) begin
            if (rr_ptr) begin
                grant_src  = SRC_MDU;
                mdu_direct = 1'b1;
            end else begin
                grant_src  = SRC_LSU;
                lsu_direct = 1'b1;
            end
            rr_ptr_next = !rr_ptr;
        end else if (lsu_valid) begin
            grant_src  = SRC_LSU;
            lsu_direct = 1'b1;
        end else if (mdu_valid) begin
            grant_src  = SRC_MDU;
            mdu_direct = 1'b1;
        end
`endif
        lsu_pop = (grant_src == SRC_LSU) && !lsu_direct;
        mdu_pop = (grant_src == SRC_MDU) && !mdu_direct;
    end

    always_comb begin
        grant_rd   = '0;
        grant_data = '0;
        unique case (grant_src)
            SRC_ALU: begin
                grant_rd   = alu_rd;
                grant_data = alu_data;
            end
            SRC_LSU: begin
                grant_rd   = lsu_direct ? lsu_rd   : lsu_buf.rd;
                grant_data = lsu_direct ? lsu_data : lsu_buf.data;
            end
            SRC_MDU: begin
                grant_rd   = mdu_direct ? mdu_rd   : mdu_buf.rd;
                grant_data = mdu_direct ? mdu_data : mdu_buf.data;
            end
            default: begin
                grant_rd   = '0;
                grant_data = '0;
            end
        endcase
    end

    // Set is applied after clear so a same-edge issue to the retiring rd keeps it busy.
    always_comb begin
        busy_next = busy;
        if (grant_src == SRC_LSU || grant_src == SRC_MDU)
            busy_next[grant_rd] = 1'b0;
        if (issue_valid && issue_rd != '0)
            busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_reg_write <= 1'b0;
            rf_rd        <= '0;
            rf_result    <= '0;
            busy         <= '0;
            rr_ptr       <= 1'b0;
        end else begin
            rr_ptr       <= rr_ptr_next;
            busy         <= busy_next;
            rf_reg_write <= (grant_src != SRC_NONE) && (grant_rd != '0);
            if (grant_src != SRC_NONE) begin
                rf_rd     <= grant_rd;
                rf_result <= grant_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_writer.sv
// Scoreboard bench for wb_writer: directed scenarios then random traffic,
// checked against a per-source reference model of the writeback rules.
`timescale 1ns/1ps
module tb_wb_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0, lsu_valid = 1'b0, mdu_valid = 1'b0, issue_valid = 1'b0;
    logic [4:0]  alu_rd = '0, lsu_rd = '0, mdu_rd = '0, issue_rd = '0;
    logic [31:0] alu_data = '0, lsu_data = '0, mdu_data = '0;
    logic        lsu_ready, mdu_ready, rf_reg_write;
    logic [31:0] busy;
    logic [4:0]  rf_rd;
    logic [31:0] rf_result;

    wb_writer #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy),
        .rf_rd(rf_rd), .rf_result(rf_result), .rf_reg_write(rf_reg_write)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    endtask

    typedef struct { logic [4:0] rd; logic [31:0] d; } res_t;
    typedef struct { int cyc; logic [4:0] rd; logic [31:0] d; } wr_t;

    res_t lsu_q[$];
    res_t mdu_q[$];
    wr_t  exp_q[$];

    // Reference state, index 0 = LSU, 1 = MDU; m_* is the state now, n_* after the next edge.
    logic        m_bv[2], n_bv[2];
    logic [4:0]  m_brd[2], n_brd[2];
    logic [31:0] m_bd[2], n_bd[2];
    int          m_pref, n_pref;
    logic [31:0] m_busy, n_busy;
    logic [4:0]  m_out_rd, n_out_rd;
    logic [31:0] m_out_d, n_out_d;

    logic        a_v = 1'b0, i_v = 1'b0;
    logic [4:0]  a_rd = '0, i_rd = '0;
    logic [31:0] a_d = '0;

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_bv[s] = 1'b0; m_brd[s] = '0; m_bd[s] = '0;
            n_bv[s] = 1'b0; n_brd[s] = '0; n_bd[s] = '0;
        end
        m_pref = 0; n_pref = 0; m_busy = '0; n_busy = '0;
        m_out_rd = '0; n_out_rd = '0; m_out_d = '0; n_out_d = '0;
    endtask

    task automatic commit();
        for (int s = 0; s < 2; s++) begin
            m_bv[s] = n_bv[s]; m_brd[s] = n_brd[s]; m_bd[s] = n_bd[s];
        end
        m_pref = n_pref; m_busy = n_busy; m_out_rd = n_out_rd; m_out_d = n_out_d;
    endtask

    // Drive this cycle's inputs and work out the outcome of the coming edge.
    task automatic step();
        res_t        off[2];
        logic        ov[2], acc[2], direct[2];
        int          w, nfull;
        logic [4:0]  wrd;
        logic [31:0] wd;
        ov[0] = lsu_q.size() > 0;
        ov[1] = mdu_q.size() > 0;
        off[0] = ov[0] ? lsu_q[0] : '{rd: 5'($urandom), d: $urandom};
        off[1] = ov[1] ? mdu_q[0] : '{rd: 5'($urandom), d: $urandom};
        lsu_valid = ov[0]; lsu_rd = off[0].rd; lsu_data = off[0].d;
        mdu_valid = ov[1]; mdu_rd = off[1].rd; mdu_data = off[1].d;
        alu_valid = a_v; alu_rd = a_rd; alu_data = a_d;
        issue_valid = i_v; issue_rd = i_rd;

        for (int s = 0; s < 2; s++) begin
            acc[s] = ov[s] && !m_bv[s];
            direct[s] = 1'b0;
            n_bv[s] = m_bv[s]; n_brd[s] = m_brd[s]; n_bd[s] = m_bd[s];
        end
        n_pref = m_pref; n_busy = m_busy; n_out_rd = m_out_rd; n_out_d = m_out_d;
        nfull = int'(m_bv[0]) + int'(m_bv[1]);
        w = -1; wrd = '0; wd = '0;
        if (a_v) begin
            w = 2; wrd = a_rd; wd = a_d;
        end else if (nfull == 2) begin
            w = m_pref; n_pref = 1 - m_pref;
        end else if (nfull == 1) begin
            w = m_bv[0] ? 0 : 1;
        end
`ifdef WB_BYPASS_EN
        else if (acc[0] && acc[1]) begin
            w = m_pref; n_pref = 1 - m_pref; direct[w] = 1'b1;
        end else if (acc[0] || acc[1]) begin
            w = acc[0] ? 0 : 1; direct[w] = 1'b1;
        end
`endif
        if (w == 0 || w == 1) begin
            if (direct[w]) begin
                wrd = off[w].rd; wd = off[w].d;
            end else begin
                wrd = m_brd[w]; wd = m_bd[w]; n_bv[w] = 1'b0;
            end
            n_busy[wrd] = 1'b0;
        end
        for (int s = 0; s < 2; s++)
            if (acc[s] && !direct[s]) begin
                n_bv[s] = 1'b1; n_brd[s] = off[s].rd; n_bd[s] = off[s].d;
            end
        if (w >= 0) begin
            n_out_rd = wrd; n_out_d = wd;
            if (wrd != 0) exp_q.push_back('{cyc: cyc + 1, rd: wrd, d: wd});
        end
        if (i_v && i_rd != 0) n_busy[i_rd] = 1'b1;
        n_busy[0] = 1'b0;
        if (acc[0]) void'(lsu_q.pop_front());
        if (acc[1]) void'(mdu_q.pop_front());
    endtask

    task automatic go();
        step();
        a_v = 1'b0; i_v = 1'b0;
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        a_v = 1'b1; a_rd = rd; a_d = d;
    endtask

    task automatic issue(input logic [4:0] rd);
        i_v = 1'b1; i_rd = rd;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) go();
    endtask

    always @(negedge clk) begin
        check("lsu_ready", {31'd0, lsu_ready}, {31'd0, !m_bv[0]});
        check("mdu_ready", {31'd0, mdu_ready}, {31'd0, !m_bv[1]});
        check("busy", busy, m_busy);
        check("rf_rd", {27'd0, rf_rd}, {27'd0, m_out_rd});
        check("rf_result", rf_result, m_out_d);
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            check("rf_reg_write", {31'd0, rf_reg_write}, 32'd1);
            check("write_rd", {27'd0, rf_rd}, {27'd0, exp_q[0].rd});
            check("write_data", rf_result, exp_q[0].d);
            void'(exp_q.pop_front());
        end else begin
            check("rf_reg_write_idle", {31'd0, rf_reg_write}, 32'd0);
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        alu(5'd5, 32'hDEAD_BEEF); go();
        idle(2);

        issue(5'd7); go();
        lsu_q.push_back('{rd: 5'd7, d: 32'h11}); go();
        for (int k = 0; k < 3; k++) begin alu(5'd8, 32'h100 + k); go(); end
        idle(3);

        lsu_q.push_back('{rd: 5'd9,  d: 32'hA});
        mdu_q.push_back('{rd: 5'd10, d: 32'hB});
        alu(5'd1, 32'h1); go();
        alu(5'd2, 32'h2); go();
        idle(3);
        lsu_q.push_back('{rd: 5'd9,  d: 32'hA1});
        mdu_q.push_back('{rd: 5'd10, d: 32'hB1});
        alu(5'd1, 32'h3); go();
        alu(5'd2, 32'h4); go();
        idle(3);

        issue(5'd0); go();
        issue(5'd12); go();
        mdu_q.push_back('{rd: 5'd0,  d: 32'hC0});
        mdu_q.push_back('{rd: 5'd12, d: 32'hC12});
        idle(6);

        issue(5'd12); go();
        mdu_q.push_back('{rd: 5'd12, d: 32'hCC});
        alu(5'd3, 32'h33); go();
        alu(5'd3, 32'h34); go();
        issue(5'd12); go();
        idle(3);

        issue(5'd7); go();
        issue(5'd10); go();
        lsu_q.push_back('{rd: 5'd20, d: 32'h20});
        mdu_q.push_back('{rd: 5'd21, d: 32'h21});
        alu(5'd4, 32'h44); go();
        alu(5'd4, 32'h45); go();
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 32'd0);
        check("rst_rf_reg_write", {31'd0, rf_reg_write}, 32'd0);
        check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        check("rst_mdu_ready", {31'd0, mdu_ready}, 32'd1);
        model_reset();
        exp_q.delete(); lsu_q.delete(); mdu_q.delete();
        lsu_valid = 1'b0; mdu_valid = 1'b0; alu_valid = 1'b0; issue_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(2, 0) == 0) alu(5'($urandom), $urandom);
            if (lsu_q.size() < 2 && $urandom_range(2, 0) == 0)
                lsu_q.push_back('{rd: 5'($urandom), d: $urandom});
            if (mdu_q.size() < 2 && $urandom_range(2, 0) == 0)
                mdu_q.push_back('{rd: 5'($urandom), d: $urandom});
            if ($urandom_range(3, 0) == 0) issue(5'($urandom));
            go();
        end
        idle(8);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
- Writeback-side initiator for the integer register file; it produces the single write port (rd, result, reg_write) that the register file consumes.
- Merges three result sources into at most one register write per cycle:
  - single-cycle ALU, which is never stalled;
  - LSU load data, valid/ready;
  - multiply/divide unit (MDU), valid/ready.
- Keeps a 32-bit pending-write scoreboard so issue logic can stall on long-latency destinations.

Parameters:
- XLEN, 32, data width.
- NREG, 32, architectural register count; the scoreboard is NREG bits wide.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_valid  in  1  ALU result present this cycle; always accepted.
- alu_rd  in  5  ALU destination.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  load result valid.
- lsu_ready  out  1  LSU holding buffer empty.
- lsu_rd  in  5  load destination.
- lsu_data  in  XLEN  load data.
- mdu_valid  in  1  MDU result valid.
- mdu_ready  out  1  MDU holding buffer empty.
- mdu_rd  in  5  MDU destination.
- mdu_data  in  XLEN  MDU result.
- issue_valid  in  1  long-latency (load/MDU) instruction issued.
- issue_rd  in  5  its destination.
- busy  out  NREG  scoreboard; bit r = write to xr pending.
- rf_rd  out  5  register-file write address.
- rf_result  out  XLEN  register-file write data.
- rf_reg_write  out  1  register-file write enable.

Behaviour:
- Reset: asynchronous on rst_n low. Clears rf_reg_write=0, rf_rd=0, rf_result=0, busy=0, both buffers empty (so lsu_ready=mdu_ready=1), rr_ptr=0 (LSU preferred).
  - Reset mid-operation discards buffered results and pending bits; no write is emitted in the first cycle after release.
- Holding buffers: one per LSU/MDU, each holding {valid, rd, data}.
  - ready = !buf_valid, a registered-state function with no combinational path from valid.
  - Accept on valid&&ready at the clock edge.
  - A buffer drained this cycle still shows ready=0 this cycle; it is refilled from the next cycle.
- Grant, evaluated each cycle on current state:
  1. alu_valid wins unconditionally.
  2. Otherwise, if exactly one buffer is full, grant it.
  3. Otherwise, if both are full, grant per rr_ptr (0=LSU, 1=MDU); rr_ptr then points to the non-granted source.
  4. rr_ptr changes only on a contested grant.
  - ALU presence blocks drain; a buffer may wait indefinitely under continuous ALU traffic, which is accepted by design.
- Output register: granted {rd, data} is loaded into rf_rd/rf_result at the edge.
  - rf_reg_write = granted && rd!=0.
  - A grant to x0 drains the buffer but writes nothing.
  - With no grant, rf_reg_write=0 and rf_rd/rf_result hold their values.
- Latency:
  - ALU: valid in cycle N -> rf_reg_write high in cycle N+1.
  - LSU/MDU without contention: accepted at end of cycle N -> granted in N+1 -> rf_reg_write high in N+2.
- Scoreboard:
  - issue_valid && issue_rd!=0 sets busy[issue_rd].
  - A LSU/MDU grant clears busy[rd]; ALU grants never clear it.
  - Same-edge set and clear on one register: set wins.
  - busy[0] is constantly 0.
  - Issuing to an already-busy rd is legal; the bit simply stays set.

Optional Feature:
- WB_BYPASS_EN defined:
  - An LSU/MDU handshake whose buffer is empty, with alu_valid low and the other buffer empty, is granted directly in the accept cycle; the buffer stays empty, so latency is 1.
  - If both sources bypass in the same cycle, rr_ptr decides and the loser is buffered.
- Undefined: all LSU/MDU results pass through the buffer (latency 2).

Decomposition:
- Shared package (wb_pkg):
  - XLEN, NREG, REG_ADDR_W=5;
  - source enum SRC_NONE/SRC_ALU/SRC_LSU/SRC_MDU;
  - wb_entry_t {valid, rd[4:0], data[XLEN-1:0]}.
- One sub-module, wb_hold_buf: the 1-entry valid/ready holding register, instantiated twice (LSU, MDU).
- Arbitration and scoreboard stay in the top level.

Test Plan:
- ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF in cycle 3 -> cycle 4 rf_reg_write=1, rf_rd=5, rf_result=0xDEADBEEF; busy unchanged.
- LSU vs ALU:
  - stimulus: lsu x7=0x11 accepted cycle 2; alu_valid held cycles 3-5 (x8);
  - required: lsu_ready=0 cycles 3-6; x7 written in cycle 7; busy[7] (issued earlier) clears at the cycle-6 edge.
- Contention:
  - stimulus: both buffers full (lsu x9=0xA, mdu x10=0xB), rr_ptr=0;
  - required: x9 written, then x10, on consecutive cycles.
  - stimulus: refill both;
  - required: x10's source (MDU) goes first.
- x0 and scoreboard:
  - stimulus: issue x0 and x12; mdu result to x0, then to x12;
  - required: busy[0] stays 0; x0 grant gives rf_reg_write=0 but mdu_ready returns to 1; busy[12] 1 -> 0.
- Set/clear collision: issue_rd=12 on the same edge as the x12 MDU grant -> busy[12] remains 1.
- Reset:
  - stimulus: rst_n low mid-cycle with both buffers full and busy=0x0000_1480;
  - required: immediately busy=0, rf_reg_write=0, ready=1; after release, no write in the next cycle.
- Bypass (macro defined): lsu x3=0x55 accepted cycle 2 with nothing else pending -> rf_reg_write in cycle 3.
